// File: rtl/approx_err_sweeper.sv
// approx_err_sweeper: exhaustive input sweep and error-metric accumulator
// for characterising an approximate combinational circuit against its
// exact golden counterpart. Stage 1 captures the vector and both results;
// stage 2 folds the absolute difference into the running metrics.
module approx_err_sweeper #(
  parameter int IN_W  = 4,
  parameter int OUT_W = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_i,
  output logic [IN_W-1:0]       vec_o,
  input  logic [OUT_W-1:0]      approx_i,
  input  logic [OUT_W-1:0]      exact_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [IN_W:0]         err_cnt_o,
  output logic [IN_W+OUT_W-1:0] sum_err_o,
  output logic [OUT_W-1:0]      max_err_o,
  output logic [IN_W-1:0]       worst_vec_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [IN_W-1:0] LAST_VEC = '1;

  state_t               state;
  logic                 s1_valid;
  logic [IN_W-1:0]      s1_vec;
  logic [OUT_W-1:0]     s1_approx;
  logic [OUT_W-1:0]     s1_exact;
  logic [OUT_W:0]       diff_pos;
  logic [OUT_W:0]       diff_neg;
  logic [OUT_W-1:0]     abs_err;

  // Absolute difference of the captured pair; the extra bit is the borrow
  // that tells us which subtraction order gives the magnitude.
  always_comb begin
    diff_pos = {1'b0, s1_exact} - {1'b0, s1_approx};
    diff_neg = {1'b0, s1_approx} - {1'b0, s1_exact};
    abs_err  = diff_pos[OUT_W] ? diff_neg[OUT_W-1:0] : diff_pos[OUT_W-1:0];
  end

  // Sweep FSM, stage-1 capture and stage-2 metric accumulation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      vec_o       <= '0;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
      err_cnt_o   <= '0;
      sum_err_o   <= '0;
      max_err_o   <= '0;
      worst_vec_o <= '0;
      s1_valid    <= 1'b0;
      s1_vec      <= '0;
      s1_approx   <= '0;
      s1_exact    <= '0;
    end else begin
      if (s1_valid) begin
        if (abs_err != '0) begin
          err_cnt_o <= err_cnt_o + {{IN_W{1'b0}}, 1'b1};
        end
        sum_err_o <= sum_err_o + {{IN_W{1'b0}}, abs_err};
        if (abs_err > max_err_o) begin
          max_err_o   <= abs_err;
          worst_vec_o <= s1_vec;
        end
      end

      case (state)
        IDLE, DONE: begin
          if (start_i) begin
            state       <= SWEEP;
            vec_o       <= '0;
            busy_o      <= 1'b1;
            done_o      <= 1'b0;
            err_cnt_o   <= '0;
            sum_err_o   <= '0;
            max_err_o   <= '0;
            worst_vec_o <= '0;
          end
        end
        SWEEP: begin
          s1_valid  <= 1'b1;
          s1_vec    <= vec_o;
          s1_approx <= approx_i;
          s1_exact  <= exact_i;
          if (vec_o == LAST_VEC) begin
            state <= DRAIN;
          end else begin
            vec_o <= vec_o + {{(IN_W-1){1'b0}}, 1'b1};
          end
        end
        DRAIN: begin
          s1_valid <= 1'b0;
          state    <= DONE;
          busy_o   <= 1'b0;
          done_o   <= 1'b1;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_approx_err_sweeper.sv
// tb_approx_err_sweeper: drives full sweeps against a 2-bit absolute
// difference circuit (a = vec[1:0], b = vec[3:2]) and several deliberately
// faulty approximations, checking metrics through a done-triggered
// scoreboard.
module tb_approx_err_sweeper;

  localparam int IN_W  = 4;
  localparam int OUT_W = 2;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic                  start_i;
  logic [IN_W-1:0]       vec_o;
  logic [OUT_W-1:0]      approx_i;
  logic [OUT_W-1:0]      exact_i;
  logic                  busy_o;
  logic                  done_o;
  logic [IN_W:0]         err_cnt_o;
  logic [IN_W+OUT_W-1:0] sum_err_o;
  logic [OUT_W-1:0]      max_err_o;
  logic [IN_W-1:0]       worst_vec_o;

  // 0: approx = exact, 1: approx stuck at 0, 2: po1 inverted, 3: po0 inverted
  int mode;
  int passCount  = 0;
  int checkCount = 0;

  typedef struct {
    int errCnt;
    int sumErr;
    int maxErr;
    int worstVec;
  } expect_t;

  expect_t expQ[$];

  logic [1:0] ga;
  logic [1:0] gb;

  approx_err_sweeper #(.IN_W(IN_W), .OUT_W(OUT_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_i     (start_i),
    .vec_o       (vec_o),
    .approx_i    (approx_i),
    .exact_i     (exact_i),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .err_cnt_o   (err_cnt_o),
    .sum_err_o   (sum_err_o),
    .max_err_o   (max_err_o),
    .worst_vec_o (worst_vec_o)
  );

  always #5 clk = ~clk;

  // Golden |a-b| circuit and the selected approximation, both combinational.
  always_comb begin
    ga      = vec_o[1:0];
    gb      = vec_o[3:2];
    exact_i = (ga >= gb) ? (ga - gb) : (gb - ga);
    case (mode)
      1:       approx_i = 2'b00;
      2:       approx_i = exact_i ^ 2'b10;
      3:       approx_i = exact_i ^ 2'b01;
      default: approx_i = exact_i;
    endcase
  end

  task automatic checkOutput(input string name, input int act, input int exp);
    checkCount++;
    if (act == exp) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Monitor: on each rising done_o, pop the expected metrics and compare.
  initial begin
    logic donePrev;
    expect_t e;
    donePrev = 1'b0;
    forever begin
      @(negedge clk);
      if (done_o && !donePrev) begin
        if (expQ.size() == 0) begin
          checkOutput("unexpectedDone", 1, 0);
        end else begin
          e = expQ.pop_front();
          checkOutput("errCnt",   int'(err_cnt_o),   e.errCnt);
          checkOutput("sumErr",   int'(sum_err_o),   e.sumErr);
          checkOutput("maxErr",   int'(max_err_o),   e.maxErr);
          checkOutput("worstVec", int'(worst_vec_o), e.worstVec);
        end
      end
      donePrev = done_o;
    end
  end

  // Called just after the accept edge; follows the sweep until done_o.
  task automatic waitSweep(input logic holdStart);
    int latency;
    latency = -1;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (n == 0) begin
        checkOutput("busyAtAccept", int'(busy_o), 1);
        checkOutput("doneDropAtAccept", int'(done_o), 0);
        start_i = holdStart;
      end
      if (n < 16) begin
        checkOutput($sformatf("vecSeq%0d", n), int'(vec_o), n);
      end
      if (done_o) begin
        latency = n;
        break;
      end
    end
    checkOutput("doneLatency", latency, 17);
    checkOutput("busyAtDone", int'(busy_o), 0);
  endtask

  task automatic applyStimulus(input int m, input int eErr, input int eSum,
                               input int eMax, input int eWorst,
                               input logic holdStart);
    expect_t e;
    @(negedge clk);
    mode     = m;
    e.errCnt   = eErr;
    e.sumErr   = eSum;
    e.maxErr   = eMax;
    e.worstVec = eWorst;
    expQ.push_back(e);
    start_i = 1'b1;
    @(posedge clk);
    waitSweep(holdStart);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_vec"},   int'(vec_o),       0);
    checkOutput({tag, "_busy"},  int'(busy_o),      0);
    checkOutput({tag, "_done"},  int'(done_o),      0);
    checkOutput({tag, "_err"},   int'(err_cnt_o),   0);
    checkOutput({tag, "_sum"},   int'(sum_err_o),   0);
    checkOutput({tag, "_max"},   int'(max_err_o),   0);
    checkOutput({tag, "_worst"}, int'(worst_vec_o), 0);
  endtask

  // Watchdog so a stuck design can never hang the run.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    expect_t e;
    rst_n   = 1'b0;
    start_i = 1'b0;
    mode    = 0;
    repeat (2) @(negedge clk);
    checkAllZero("reset");
    rst_n = 1'b1;

    // Exact approximation: no error at all.
    applyStimulus(0, 0, 0, 0, 0, 1'b0);
    // Stuck-at-0: twelve nonzero diffs summing to 20, worst at a=3,b=0.
    applyStimulus(1, 12, 20, 3, 3, 1'b0);
    // po1 inverted: every vector off by exactly 2.
    applyStimulus(2, 16, 32, 2, 0, 1'b0);

    // Mid-sweep asynchronous reset wipes partial metrics immediately.
    @(negedge clk);
    mode    = 1;
    start_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_i = 1'b0;
    repeat (7) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkAllZero("midReset");
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(1, 12, 20, 3, 3, 1'b0);

    // start_i held high: no restart while busy, restart right after DONE.
    applyStimulus(0, 0, 0, 0, 0, 1'b1);
    e.errCnt   = 0;
    e.sumErr   = 0;
    e.maxErr   = 0;
    e.worstVec = 0;
    expQ.push_back(e);
    @(posedge clk);
    waitSweep(1'b0);

    // Back-to-back sweeps with different faults stay independent.
    applyStimulus(2, 16, 32, 2, 0, 1'b0);
    applyStimulus(3, 16, 16, 1, 0, 1'b0);

    repeat (3) @(negedge clk);
    checkOutput("queueDrained", expQ.size(), 0);
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
